// File: rtl/sfifo_sram_fwft.sv
// Synchronous FIFO on a simple-dual-port array with a registered read, fronted by a
// 2-entry skid buffer that presents the head word first-word-fall-through.
`ifndef DATA_WIDTH_BUFF_SO_SEG
`define DATA_WIDTH_BUFF_SO_SEG 8
`endif
`ifndef BITS_SLOW_BLK_BUFF_ADDR
`define BITS_SLOW_BLK_BUFF_ADDR 4
`endif

module sfifo_sram_fwft #(
    parameter int DSIZE     = `DATA_WIDTH_BUFF_SO_SEG,
    parameter int ASIZE     = `BITS_SLOW_BLK_BUFF_ADDR,
    parameter int AFULL_TH  = (1 << ASIZE) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    input  logic             flush,
    output logic [ASIZE:0]   count,
    output logic             err_ovf,
    output logic             err_udf
);
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_TH);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [DSIZE-1:0] mem_rdata_q;
    logic [DSIZE-1:0] skid0_q, skid0_d, skid1_q, skid1_d;
    logic [ASIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic [1:0]       skid_cnt_q, skid_cnt_d, cnt_p;
    logic             inflight_q, inflight_d;
    logic             err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
    logic             arr_empty, arr_full, wr_acc, pop_acc, rd_issue;
    logic [2:0]       occ;

    assign arr_empty = (wptr_q == rptr_q);
    assign arr_full  = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                       (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);

    assign wfull         = arr_full;
    assign rempty        = (skid_cnt_q == 2'd0);
    assign rdata         = skid0_q;
    assign count         = count_q;
    assign walmost_full  = (count_q >= AFULL_C);
    assign ralmost_empty = (count_q <= AEMPTY_C);
    assign err_ovf       = err_ovf_q;
    assign err_udf       = err_udf_q;

    always_comb begin
        wr_acc  = winc && !arr_full && !flush;
        pop_acc = rinc && (skid_cnt_q != 2'd0) && !flush;
        // Occupancy the skid will see once the in-flight word lands and the pop retires.
        occ      = {1'b0, skid_cnt_q} + {2'b0, inflight_q} - {2'b0, pop_acc};
        rd_issue = !arr_empty && (occ < 3'd2) && !flush;

        wptr_d     = wptr_q + {{ASIZE{1'b0}}, wr_acc};
        rptr_d     = rptr_q + {{ASIZE{1'b0}}, rd_issue};
        count_d    = count_q + {{ASIZE{1'b0}}, wr_acc} - {{ASIZE{1'b0}}, pop_acc};
        inflight_d = rd_issue;
        err_ovf_d  = err_ovf_q | (winc && arr_full && !flush);
        err_udf_d  = err_udf_q | (rinc && (skid_cnt_q == 2'd0) && !flush);

        skid0_d = skid0_q;
        skid1_d = skid1_q;
        cnt_p   = skid_cnt_q;
        if (pop_acc) begin
            skid0_d = skid1_q;
            cnt_p   = skid_cnt_q - 2'd1;
        end
        skid_cnt_d = cnt_p;
        // Returned array data joins the tail, after any shift from this cycle's pop.
        if (inflight_q && !flush) begin
            if (cnt_p == 2'd0) skid0_d = mem_rdata_q;
            else               skid1_d = mem_rdata_q;
            skid_cnt_d = cnt_p + 2'd1;
        end

        if (flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            skid_cnt_d = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            skid_cnt_q <= '0;
            inflight_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            skid_cnt_q <= skid_cnt_d;
            inflight_q <= inflight_d;
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
        end
    end

    // Array and data registers carry no reset; occupancy state qualifies them.
    always_ff @(posedge clk) begin
        if (wr_acc)   mem[wptr_q[ASIZE-1:0]] <= wdata;
        if (rd_issue) mem_rdata_q <= mem[rptr_q[ASIZE-1:0]];
        skid0_q <= skid0_d;
        skid1_q <= skid1_d;
    end
endmodule

// File: tb/tb_sfifo_sram_fwft.sv
// Bench for sfifo_sram_fwft: directed scenarios with exact timing plus a randomized
// run checked against a queue model of the FIFO contents.
module tb_sfifo_sram_fwft;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wdata = '0;
    logic       winc = 1'b0, rinc = 1'b0, flush = 1'b0;
    logic       wfull, walmost_full, rempty, ralmost_empty, err_ovf, err_udf;
    logic [7:0] rdata;
    logic [2:0] count;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    sfifo_sram_fwft #(.DSIZE(8), .ASIZE(2), .AFULL_TH(4), .AEMPTY_TH(1)) dut (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(wfull),
        .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata), .rempty(rempty),
        .ralmost_empty(ralmost_empty), .flush(flush), .count(count),
        .err_ovf(err_ovf), .err_udf(err_udf));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        winc = 1'b0; rinc = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL reset_rempty got %b exp 1", rempty); end
        n_cmp++; if (wfull !== 1'b0) begin n_err++; $display("FAIL reset_wfull got %b exp 0", wfull); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (walmost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b exp 0", walmost_full); end
        n_cmp++; if (ralmost_empty !== 1'b1) begin n_err++; $display("FAIL reset_aempty got %b exp 1", ralmost_empty); end
        n_cmp++; if ({err_ovf, err_udf} !== 2'b00) begin n_err++; $display("FAIL reset_err got %b exp 00", {err_ovf, err_udf}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        wdata = 8'hA5; winc = 1'b1;
        tick();
        winc = 1'b0;
        n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL single_t0_rempty got %b exp 1", rempty); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count got %0d exp 1", count); end
        tick();
        n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL single_t1_rempty got %b exp 1", rempty); end
        tick();
        n_cmp++; if (rempty !== 1'b0) begin n_err++; $display("FAIL single_t2_rempty got %b exp 0", rempty); end
        n_cmp++; if (rdata !== 8'hA5) begin n_err++; $display("FAIL single_rdata got %h exp a5", rdata); end
        n_cmp++; if (ralmost_empty !== 1'b1) begin n_err++; $display("FAIL single_aempty got %b exp 1", ralmost_empty); end
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        n_cmp++; if (rempty !== 1'b1 || count !== 3'd0) begin n_err++; $display("FAIL single_pop got rempty=%b count=%0d exp 1/0", rempty, count); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 6; i++) begin
            wdata = 8'(i); winc = 1'b1;
            tick();
            if (i == 5) begin
                n_cmp++; if (wfull !== 1'b0) begin n_err++; $display("FAIL fill5_wfull got %b exp 0", wfull); end
            end
        end
        winc = 1'b0;
        n_cmp++; if (wfull !== 1'b1) begin n_err++; $display("FAIL fill_wfull got %b exp 1", wfull); end
        n_cmp++; if (count !== 3'd6) begin n_err++; $display("FAIL fill_count got %0d exp 6", count); end
        n_cmp++; if (walmost_full !== 1'b1) begin n_err++; $display("FAIL fill_afull got %b exp 1", walmost_full); end
        n_cmp++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL fill_ovf_pre got %b exp 0", err_ovf); end
        wdata = 8'h77; winc = 1'b1;
        tick();
        winc = 1'b0;
        n_cmp++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", err_ovf); end
        n_cmp++; if (count !== 3'd6) begin n_err++; $display("FAIL ovf_count got %0d exp 6", count); end
    endtask

    task automatic test_drain();
        rinc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (rempty !== 1'b0 || rdata !== 8'(i + 1)) begin n_err++; $display("FAIL drain_%0d got rempty=%b rdata=%h exp 0/%h", i, rempty, rdata, 8'(i + 1)); end
            tick();
        end
        rinc = 1'b0;
        n_cmp++; if (rempty !== 1'b1 || count !== 3'd0) begin n_err++; $display("FAIL drain_end got rempty=%b count=%0d exp 1/0", rempty, count); end
        n_cmp++; if (err_udf !== 1'b0) begin n_err++; $display("FAIL drain_udf got %b exp 0", err_udf); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wdata = 8'($urandom); winc = 1'b1; q.push_back(wdata);
            tick();
        end
        for (int c = 0; c < 100; c++) begin
            n_cmp++; if (rempty !== 1'b0 || rdata !== q[0]) begin n_err++; $display("FAIL stream_%0d got rempty=%b rdata=%h exp 0/%h", c, rempty, rdata, q[0]); end
            n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL stream_count_%0d got %0d exp 3", c, count); end
            wdata = 8'($urandom); winc = 1'b1; rinc = 1'b1;
            tick();
            void'(q.pop_front());
            q.push_back(wdata);
        end
        idle();
        n_cmp++; if ({err_ovf, err_udf} !== 2'b00) begin n_err++; $display("FAIL stream_err got %b exp 00", {err_ovf, err_udf}); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wdata = 8'h11 + 8'(i); winc = 1'b1;
            tick();
        end
        winc = 1'b0; rinc = 1'b1;
        tick();
        rinc = 1'b0;
        n_cmp++; if (count !== 3'd5) begin n_err++; $display("FAIL flush_pre_count got %0d exp 5", count); end
        flush = 1'b1; winc = 1'b1; rinc = 1'b1; wdata = 8'h99;
        tick();
        idle();
        n_cmp++; if (count !== 3'd0 || rempty !== 1'b1 || wfull !== 1'b0) begin n_err++; $display("FAIL flush_state got count=%0d rempty=%b wfull=%b exp 0/1/0", count, rempty, wfull); end
        n_cmp++; if ({err_ovf, err_udf} !== 2'b00) begin n_err++; $display("FAIL flush_err got %b exp 00", {err_ovf, err_udf}); end
        tick(); tick();
        n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL flush_inflight got rempty=%b exp 1", rempty); end
        wdata = 8'h3C; winc = 1'b1;
        tick();
        winc = 1'b0;
        tick(); tick();
        n_cmp++; if (rempty !== 1'b0 || rdata !== 8'h3C || count !== 3'd1) begin n_err++; $display("FAIL flush_after got rempty=%b rdata=%h count=%0d exp 0/3c/1", rempty, rdata, count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        n_cmp++; if (err_udf !== 1'b1) begin n_err++; $display("FAIL udf_set got %b exp 1", err_udf); end
        for (int i = 0; i < 4; i++) begin
            wdata = 8'h40 + 8'(i); winc = 1'b1;
            tick();
        end
        winc = 1'b0;
        n_cmp++; if (count !== 3'd4 || walmost_full !== 1'b1) begin n_err++; $display("FAIL mid_pre got count=%0d afull=%b exp 4/1", count, walmost_full); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (rempty !== 1'b1 || count !== 3'd0) begin n_err++; $display("FAIL mid_reset got rempty=%b count=%0d exp 1/0", rempty, count); end
        n_cmp++; if ({err_ovf, err_udf} !== 2'b00) begin n_err++; $display("FAIL mid_reset_err got %b exp 00", {err_ovf, err_udf}); end
        @(negedge clk);
        rst_n = 1'b1;
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        n_cmp++; if (err_udf !== 1'b1 || rempty !== 1'b1) begin n_err++; $display("FAIL mid_udf got udf=%b rempty=%b exp 1/1", err_udf, rempty); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int pw;
            pw = ((c / 150) % 2 == 0) ? 70 : 30;
            n_cmp++; if (count !== 3'(q.size())) begin n_err++; $display("FAIL rnd_count_%0d got %0d exp %0d", c, count, q.size()); end
            if (rempty === 1'b0 && q.size() > 0) begin
                n_cmp++; if (rdata !== q[0]) begin n_err++; $display("FAIL rnd_rdata_%0d got %h exp %h", c, rdata, q[0]); end
            end
            if (q.size() >= 3) begin
                n_cmp++; if (rempty !== 1'b0) begin n_err++; $display("FAIL rnd_bubble_%0d got rempty=%b exp 0", c, rempty); end
            end
            if (q.size() == 0) begin
                n_cmp++; if (rempty !== 1'b1) begin n_err++; $display("FAIL rnd_empty_%0d got rempty=%b exp 1", c, rempty); end
            end
            if (q.size() < 4) begin
                n_cmp++; if (wfull !== 1'b0) begin n_err++; $display("FAIL rnd_wfull_lo_%0d got %b exp 0", c, wfull); end
            end
            if (q.size() == 6) begin
                n_cmp++; if (wfull !== 1'b1) begin n_err++; $display("FAIL rnd_wfull_hi_%0d got %b exp 1", c, wfull); end
            end
            n_cmp++; if (walmost_full !== (q.size() >= 4) || ralmost_empty !== (q.size() <= 1)) begin n_err++; $display("FAIL rnd_flags_%0d got af=%b ae=%b size=%0d", c, walmost_full, ralmost_empty, q.size()); end
            wdata = 8'($urandom);
            winc  = ($urandom_range(0, 99) < pw) && !wfull;
            rinc  = ($urandom_range(0, 99) < 100 - pw) && !rempty;
            flush = ($urandom_range(0, 99) == 0);
            tick();
            if (flush) q.delete();
            else begin
                if (rinc) void'(q.pop_front());
                if (winc) q.push_back(wdata);
            end
        end
        idle();
        n_cmp++; if ({err_ovf, err_udf} !== 2'b00) begin n_err++; $display("FAIL rnd_err got %b exp 00", {err_ovf, err_udf}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
